// File: rtl/mc_sequencer.sv
// mc_sequencer: multicycle RV32I main FSM with memory-ready stalls and trap on bad encodings
module mc_sequencer #(
  parameter bit ENABLE_BNE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mem_ready,
  input  logic       zero,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [1:0] imm_src,
  output logic       trap,
  output logic [3:0] state
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3, MEMWB = 4'd4,
    MEMWRITE = 4'd5, EXECR = 4'd6, EXECI = 4'd7, ALUWB = 4'd8, BRANCH = 4'd9,
    JAL = 4'd10, ERROR = 4'd15
  } state_t;
  state_t st;
  logic pc_w, ir_w, rw, mw;
  logic unused_funct7;
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};
  wire is_lw  = opcode == 7'b0000011;
  wire is_sw  = opcode == 7'b0100011;
  wire is_r   = opcode == 7'b0110011;
  wire is_i   = opcode == 7'b0010011;
  wire is_br  = opcode == 7'b1100011;
  wire is_jal = opcode == 7'b1101111;
  wire alu_ok = funct3 == 3'b000 || funct3 == 3'b100 || funct3 == 3'b110 ||
                funct3 == 3'b111 || funct3 == 3'b010;
  wire br_ok  = funct3 == 3'b000 || (ENABLE_BNE && funct3 == 3'b001);
  wire sub_r  = (st == EXECR) && funct7[5];
  wire [2:0] alu_dec = funct3 == 3'b000 ? (sub_r ? 3'b001 : 3'b000) :
                       funct3 == 3'b100 ? 3'b100 :
                       funct3 == 3'b110 ? 3'b011 :
                       funct3 == 3'b111 ? 3'b010 : 3'b101;
  wire [1:0] imm_dec = is_sw ? 2'b01 : is_br ? 2'b10 : is_jal ? 2'b11 : 2'b00;
  wire state_t dec_next = (is_lw || is_sw) ? MEMADR :
                          (is_r && alu_ok) ? EXECR :
                          (is_i && alu_ok) ? EXECI :
                          (is_br && br_ok) ? BRANCH :
                          is_jal ? JAL : ERROR;
  // state register and transitions; reset wins over everything including ERROR
  always_ff @(posedge clk) begin
    if (reset) st <= FETCH;
    else
      case (st)
        FETCH:    st <= mem_ready ? DECODE : FETCH;
        DECODE:   st <= dec_next;
        MEMADR:   st <= is_sw ? MEMWRITE : MEMREAD;
        MEMREAD:  st <= mem_ready ? MEMWB : MEMREAD;
        MEMWRITE: st <= mem_ready ? FETCH : MEMWRITE;
        EXECR:    st <= ALUWB;
        EXECI:    st <= ALUWB;
        JAL:      st <= ALUWB;
        MEMWB:    st <= FETCH;
        ALUWB:    st <= FETCH;
        BRANCH:   st <= FETCH;
        default:  st <= ERROR;
      endcase
  end
  // per-state strobes and datapath selects
  always_comb begin
    pc_w = 1'b0;
    ir_w = 1'b0;
    rw = 1'b0;
    mw = 1'b0;
    adr_src = 1'b0;
    result_src = 2'b00;
    alu_src_a = 2'b00;
    alu_src_b = 2'b00;
    alu_control = 3'b000;
    imm_src = 2'b00;
    case (st)
      FETCH: begin
        pc_w = mem_ready;
        ir_w = mem_ready;
        alu_src_b = 2'b10;
        result_src = 2'b10;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src = imm_dec;
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src = is_sw ? 2'b01 : 2'b00;
      end
      MEMREAD: adr_src = 1'b1;
      MEMWB: begin
        result_src = 2'b01;
        rw = 1'b1;
      end
      MEMWRITE: begin
        adr_src = 1'b1;
        mw = 1'b1;
      end
      EXECR: begin
        alu_src_a = 2'b10;
        alu_control = alu_dec;
      end
      EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_control = alu_dec;
      end
      ALUWB: rw = 1'b1;
      BRANCH: begin
        alu_src_a = 2'b10;
        alu_control = 3'b001;
        pc_w = funct3[0] ? ~zero : zero;
      end
      JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_w = 1'b1;
      end
      default: ;
    endcase
  end
  assign pc_write = pc_w & ~reset;
  assign ir_write = ir_w & ~reset;
  assign reg_write = rw & ~reset;
  assign mem_write = mw & ~reset;
  assign trap = st == ERROR;
  assign state = st;
endmodule

// File: tb/tb_mc_sequencer.sv
// tb_mc_sequencer: per-cycle scoreboard check of mc_sequencer states, strobes and selects
module tb_mc_sequencer;
  logic clk = 1'b0, reset = 1'b1, mem_ready = 1'b1, zero = 1'b0;
  logic [6:0] opcode = '0, funct7 = '0;
  logic [2:0] funct3 = '0;
  logic pc_write, adr_src, mem_write, ir_write, reg_write, trap;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic [3:0] state;
  logic pc_write1, adr_src1, mem_write1, ir_write1, reg_write1, trap1;
  logic [1:0] result_src1, alu_src_a1, alu_src_b1, imm_src1;
  logic [2:0] alu_control1;
  logic [3:0] state1;
  mc_sequencer dut (
    .clk(clk), .reset(reset), .mem_ready(mem_ready), .zero(zero), .opcode(opcode),
    .funct3(funct3), .funct7(funct7), .pc_write(pc_write), .adr_src(adr_src),
    .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .imm_src(imm_src), .trap(trap), .state(state)
  );
  mc_sequencer #(.ENABLE_BNE(1'b0)) dut_nobne (
    .clk(clk), .reset(reset), .mem_ready(mem_ready), .zero(zero), .opcode(opcode),
    .funct3(funct3), .funct7(funct7), .pc_write(pc_write1), .adr_src(adr_src1),
    .mem_write(mem_write1), .ir_write(ir_write1), .reg_write(reg_write1),
    .result_src(result_src1), .alu_src_a(alu_src_a1), .alu_src_b(alu_src_b1),
    .alu_control(alu_control1), .imm_src(imm_src1), .trap(trap1), .state(state1)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [3:0]  st;
    logic [4:0]  strb;
    logic [11:0] dp;
    logic [3:0]  st1;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  logic nobne_err = 1'b0;
  wire [4:0] strb = {pc_write, ir_write, reg_write, mem_write, trap};
  wire [11:0] dp = {adr_src, result_src, alu_src_a, alu_src_b, alu_control, imm_src};
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask
  function automatic logic [11:0] d(input logic a, input logic [1:0] r, input logic [1:0] sa,
                                    input logic [1:0] sb, input logic [2:0] ac, input logic [1:0] im);
    return {a, r, sa, sb, ac, im};
  endfunction
  task automatic cyc(input logic r, input logic mr, input logic z, input logic [3:0] st,
                     input logic [4:0] sb, input logic [11:0] dv);
    exp_t e;
    @(negedge clk);
    reset = r;
    mem_ready = mr;
    zero = z;
    q.push_back('{st, sb, dv, nobne_err ? 4'd15 : st});
    #1;
    e = q.pop_front();
    check("state", state, e.st);
    check("strobes", strb, e.strb);
    check("selects", dp, e.dp);
    check("nobne_state", state1, e.st1);
    check("nobne_trap", trap1, e.st1 == 4'd15);
    if (r) nobne_err = 1'b0;
  endtask
  task automatic setins(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    opcode = op;
    funct3 = f3;
    funct7 = f7;
  endtask
  task automatic fetch(input logic mr);
    cyc(0, mr, 0, 4'd0, {mr, mr, 3'b000}, d(0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00));
  endtask
  task automatic decode(input logic [1:0] im);
    cyc(0, 1, 0, 4'd1, 5'b0, d(0, 2'b00, 2'b01, 2'b01, 3'b000, im));
  endtask
  task automatic aluwb();
    cyc(0, 1, 0, 4'd8, 5'b00100, d(0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00));
  endtask
  task automatic err();
    cyc(0, 1, 0, 4'd15, 5'b00001, 12'd0);
  endtask
  logic [2:0] f3s[4] = '{3'b000, 3'b100, 3'b110, 3'b111};
  logic [2:0] acs[4] = '{3'b000, 3'b100, 3'b011, 3'b010};
  initial begin
    repeat (2) @(posedge clk);
    cyc(1, 1, 0, 4'd0, 5'b0, d(0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00));
    setins(7'b0110011, 3'b000, 7'b0000000);
    fetch(1); decode(0);
    cyc(0, 1, 0, 4'd6, 5'b0, d(0, 2'b00, 2'b10, 2'b00, 3'b000, 2'b00));
    aluwb();
    setins(7'b0110011, 3'b000, 7'b0100000);
    fetch(0); fetch(1); decode(0);
    cyc(0, 1, 0, 4'd6, 5'b0, d(0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b00));
    aluwb();
    setins(7'b0110011, 3'b010, 7'b0000000);
    fetch(1); decode(0);
    cyc(0, 1, 0, 4'd6, 5'b0, d(0, 2'b00, 2'b10, 2'b00, 3'b101, 2'b00));
    aluwb();
    for (int i = 0; i < 4; i++) begin
      setins(7'b0010011, f3s[i], 7'b0100000);
      fetch(1); decode(0);
      cyc(0, 1, 0, 4'd7, 5'b0, d(0, 2'b00, 2'b10, 2'b01, acs[i], 2'b00));
      aluwb();
    end
    setins(7'b0000011, 3'b010, 7'b0);
    fetch(1); decode(0);
    cyc(0, 1, 0, 4'd2, 5'b0, d(0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00));
    cyc(0, 0, 0, 4'd3, 5'b0, d(1, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00));
    cyc(0, 0, 0, 4'd3, 5'b0, d(1, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00));
    cyc(0, 1, 0, 4'd3, 5'b0, d(1, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00));
    cyc(0, 1, 0, 4'd4, 5'b00100, d(0, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00));
    setins(7'b0100011, 3'b010, 7'b0);
    fetch(1); decode(1);
    cyc(0, 1, 0, 4'd2, 5'b0, d(0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b01));
    cyc(0, 1, 0, 4'd5, 5'b00010, d(1, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00));
    for (int b = 0; b < 2; b++)
      for (int z = 1; z >= 0; z--) begin
        setins(7'b1100011, 3'(b), 7'b0);
        fetch(1); decode(2'b10);
        if (b == 1) nobne_err = 1'b1;
        cyc(0, 1, 1'(z), 4'd9, {(b == 1) ? (z == 0) : (z == 1), 4'b0000},
            d(0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b00));
      end
    setins(7'b1101111, 3'b000, 7'b0);
    fetch(1); decode(2'b11);
    cyc(0, 1, 0, 4'd10, 5'b10000, d(0, 2'b00, 2'b01, 2'b10, 3'b000, 2'b00));
    aluwb();
    setins(7'b0000000, 3'b000, 7'b0);
    fetch(1); decode(0);
    repeat (10) err();
    cyc(1, 1, 0, 4'd15, 5'b00001, 12'd0);
    setins(7'b0010011, 3'b001, 7'b0);
    fetch(1); decode(0);
    err();
    cyc(1, 1, 0, 4'd15, 5'b00001, 12'd0);
    setins(7'b0100011, 3'b010, 7'b0);
    fetch(1); decode(1);
    cyc(0, 1, 0, 4'd2, 5'b0, d(0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b01));
    cyc(0, 0, 0, 4'd5, 5'b00010, d(1, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00));
    cyc(1, 0, 0, 4'd5, 5'b00000, d(1, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00));
    fetch(1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mc_sequencer.md
# mc_sequencer

Multicycle sequencer for the RV32I core datapath. It holds the main instruction FSM and decodes opcode, funct3 and funct7 into per-cycle strobes and mux selects for these datapath elements: PC register, instruction/old-PC register, memory address mux, register file, immediate extender, ALU source muxes, ALU operation and result mux. It adds a memory-ready handshake so that fetch and data accesses can stall, and it traps on unsupported encodings.

## Interface
- ENABLE_BNE, default 1: when 1, funct3=001 on the branch opcode is BNE; when 0, it traps.
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- mem_ready  in  1  memory completes the current access this cycle.
- zero  in  1  ALU zero flag, combinational from the current ALU inputs.
- opcode  in  7  instruction[6:0] from the instruction register.
- funct3  in  3  instruction[14:12].
- funct7  in  7  instruction[31:25]; only bit 5 is used.
- pc_write  out  1  PC register load enable.
- adr_src  out  1  memory address select: 0 = PC, 1 = result.
- mem_write  out  1  memory write enable.
- ir_write  out  1  instruction/old-PC register load enable.
- reg_write  out  1  register file write enable.
- result_src  out  2  result select: 00 = ALU-out register, 01 = data register, 10 = ALU result.
- alu_src_a  out  2  ALU A select: 00 = PC, 01 = old PC, 10 = rs1 register.
- alu_src_b  out  2  ALU B select: 00 = rs2 register, 01 = immediate, 10 = constant 4.
- alu_control  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt.
- imm_src  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- trap  out  1  high while in the ERROR state.
- state  out  4  current state, for debug.

## Operation
- States: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10, ERROR=15.
- All outputs are combinational from the state and inputs. Any strobe or select not listed for a state is 0.
- FETCH
  - Drives adr_src=0, alu_src_a=00, alu_src_b=10, alu_control=add, result_src=10.
  - ir_write=pc_write=mem_ready.
  - Moves to DECODE when mem_ready=1; otherwise stays in FETCH.
- DECODE
  - Drives alu_src_a=01, alu_src_b=01, alu_control=add, so the branch/jump target lands in the ALU-out register.
  - imm_src is taken from the opcode.
  - Next state by opcode:
    - 0000011 (lw) or 0100011 (sw) → MEMADR.
    - 0110011 → EXECR.
    - 0010011 → EXECI.
    - 1100011 → BRANCH.
    - 1101111 → JAL.
    - Any other opcode, or an illegal funct3 combination (below) → ERROR.
- MEMADR: alu_src_a=10, alu_src_b=01, add. imm_src is I for lw and S for sw. Next is MEMREAD for lw, MEMWRITE for sw.
- MEMREAD
  - adr_src=1, result_src=00.
  - Moves to MEMWB on mem_ready; otherwise holds.
- MEMWB: result_src=01, reg_write=1. Next FETCH.
- MEMWRITE
  - adr_src=1, result_src=00, mem_write=1, held until mem_ready.
  - Moves to FETCH on mem_ready.
- EXECR: alu_src_a=10, alu_src_b=00, ALU decode per funct3/funct7. Next ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, imm_src=I, ALU decode per funct3. Next ALUWB.
- ALUWB: result_src=00, reg_write=1. Next FETCH.
- BRANCH
  - Drives alu_src_a=10, alu_src_b=00, sub, result_src=00.
  - pc_write=zero for BEQ, pc_write=!zero for BNE.
  - Next FETCH.
- JAL
  - Drives alu_src_a=01, alu_src_b=10, add, result_src=00, pc_write=1.
  - The PC loads the target computed in DECODE.
  - Next ALUWB, which writes old PC+4 to rd.
- ERROR: all strobes 0, trap=1. Stays in ERROR until reset.
- ALU decode, R-type:
  - funct3=000: sub if funct7[5]=1, else add.
  - 100 → xor; 110 → or; 111 → and; 010 → slt.
  - Any other funct3 is illegal.
- ALU decode, I-type:
  - 000 → add (funct7 ignored), 100 → xor, 110 → or, 111 → and, 010 → slt.
  - Any other funct3 is illegal.
- Branch decode: funct3=000 is BEQ; 001 is BNE if ENABLE_BNE=1; anything else is illegal.
- Legality is checked in DECODE only.

## Timing
- Reset, sampled on a rising clk edge:
  - State goes to FETCH next cycle.
  - While reset is high, pc_write, ir_write, reg_write and mem_write are forced 0 regardless of state.
  - trap=0 and state=0 after reset.
- Reset wins over every transition, including ERROR and mid-stall MEMWRITE. mem_write drops in the same cycle reset is asserted.
- Cycles per instruction with mem_ready tied high:
  - lw 5, sw 4.
  - R-type and I-type 4.
  - Branch 3.
  - jal 4.
- Each mem_ready=0 cycle in FETCH, MEMREAD or MEMWRITE adds exactly one cycle. Outputs are held stable during the stall.
- mem_ready is ignored in all other states.
- No write strobe is asserted for more than one cycle, except mem_write during a stall.

## Test plan
- add x3,x1,x2 (opcode 0110011, funct3 000, funct7 0000000), mem_ready=1 → states 0,1,6,8,0; alu_control=000 in EXECR; reg_write=1 only in cycle 4.
- lw with mem_ready low for 2 cycles in MEMREAD → 7 total cycles; adr_src=1 throughout MEMREAD; reg_write=1 with result_src=01 once.
- beq, then bne, each with zero=1 and zero=0 → pc_write is 1/0 for beq and 0/1 for bne in the BRANCH cycle. Repeat bne with ENABLE_BNE=0 → ERROR.
- jal → pc_write in FETCH and JAL only; JAL selects 01/10/add; ALUWB asserts reg_write.
- Opcode 0000000, then I-type funct3=001 → ERROR after DECODE, trap=1 and held for 10 cycles. Reset → FETCH, trap=0.
- sw stalled in MEMWRITE (mem_ready=0), reset asserted → mem_write=0 in that cycle, state=0 next cycle.
